key_checker: RTL and testbench
==============================

# key_checker

Consumer side of the key-search handshake: for each candidate key, after the decrypt core finishes, this block reads the MSG_LEN decrypted bytes from the decrypted-message RAM and checks that every byte is lowercase ASCII or space. A rejected candidate produces a one-cycle `new_key` pulse to the key generator. An accepted candidate, or an exhausted key space, ends the search with a sticky result.

## Interface
- MSG_LEN, 32, number of decrypted bytes checked per candidate (≥2)
- ADDR_W, 5, RAM address width; 2^ADDR_W ≥ MSG_LEN

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle pulse: decrypt of current candidate complete, RAM contents valid
- exhausted  in  1  key generator's done level: key space exhausted
- rd_addr  out  ADDR_W  registered read address to decrypted-message RAM
- rd_data  in  8  RAM read data, valid the cycle after rd_addr is presented (1-cycle synchronous read)
- new_key  out  1  one-cycle pulse: reject current candidate, advance key
- busy  out  1  high in FETCH, CHECK, REJECT
- found  out  1  sticky: current candidate accepted
- failed  out  1  sticky: key space exhausted without a match
- reject_count  out  24  number of candidates rejected (see Configuration)

## Operation
- Valid byte: 8'h20, or 8'h61..8'h7A inclusive. Every other value is invalid, including 8'h00 and 8'h7B..8'hFF.
- State machine states: IDLE, FETCH, CHECK, REJECT, FOUND, FAIL.
- IDLE
  - exhausted=1 → FAIL.
  - Otherwise start=1 → FETCH with rd_addr=0.
  - If exhausted and start are both high in the same cycle, exhausted wins.
- FETCH: rd_addr is held; go to CHECK.
- CHECK: rd_data corresponds to rd_addr.
  - Invalid byte → REJECT.
  - Valid byte and rd_addr==MSG_LEN-1 → FOUND.
  - Valid byte otherwise → rd_addr+1, then FETCH.
- REJECT
  - exhausted=0: new_key=1 for exactly this cycle, reject_count+1, rd_addr←0, then IDLE.
  - exhausted=1: no pulse, no count, go to FAIL.
- FOUND: found=1; terminal until reset. rd_addr holds MSG_LEN-1.
- FAIL: failed=1; terminal until reset.
- start is ignored outside IDLE; it is not queued.
- found and failed are never high together.
- reject_count saturates at 24'hFFFFFF; it does not wrap.
- Reset values: rd_addr=0, new_key=0, busy=0, found=0, failed=0, reject_count=0; state=IDLE.
- Reset mid-scan aborts the scan immediately. No new_key pulse is emitted for the aborted candidate.

## Timing
- All outputs are registered or decoded directly from state; none are combinational from inputs.
- start sampled at edge 0 → FETCH in cycle 1. Byte k is checked in cycle 2k+2. Each byte costs 2 cycles.
- All MSG_LEN bytes valid → found high from cycle 2·MSG_LEN+1.
- First invalid byte at index k → new_key high in cycle 2k+3 only. Back in IDLE at cycle 2k+4; the next start is accepted from that cycle.
- exhausted high in IDLE at cycle t → failed high at t+1.

## Configuration
- KEY_CHECKER_REJECT_CNT_EN
  - Defined: the 24-bit saturating reject counter is implemented and driven to reject_count.
  - Undefined: no counter register is built; reject_count is tied to 24'h0.
  - All other behaviour is identical in both cases.

## Test plan
- MSG_LEN=32, RAM all 8'h61 → start at cycle 0; found=1 at cycle 65; new_key never pulses; busy low from cycle 65.
- Byte 5 = 8'h41, rest 8'h61 → new_key high only in cycle 13; state IDLE at 14; found=0; reject_count=1 (macro on) / 0 (macro off).
- Bytes 8'h20 and 8'h7A at indices 0 and 31, 8'h7B at index 31 on a second run → run 1 found; after reset, run 2 pulses new_key in cycle 65.
- exhausted=1 and start=1 same cycle in IDLE → failed=1 next cycle; no FETCH, rd_addr stays 0, no new_key.
- Invalid byte with exhausted rising before REJECT → no new_key pulse; failed=1 one cycle after REJECT.
- Reset asserted in CHECK at byte 10 → all outputs 0 asynchronously; after release, start rescans from rd_addr=0; 300 consecutive rejects with macro on → reject_count=300.

Source files
------------

// File: rtl/key_checker.sv
// Scans one decrypted candidate message from RAM and accepts it only if every byte is lowercase ASCII or space.
// Optional saturating reject counter is built when KEY_CHECKER_REJECT_CNT_EN is defined.
module key_checker #(
  parameter int MSG_LEN = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              exhausted_i,
  input  logic [7:0]        rd_data_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              new_key_o,
  output logic              busy_o,
  output logic              found_o,
  output logic              failed_o,
  output logic [23:0]       reject_count_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CHECK,
    S_REJECT,
    S_FOUND,
    S_FAIL
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pulse_q, pulse_d;
  logic              byte_ok;
  logic              last_byte;

  assign byte_ok   = (rd_data_i == 8'h20) || ((rd_data_i >= 8'h61) && (rd_data_i <= 8'h7A));
  assign last_byte = (addr_q == ADDR_W'(MSG_LEN - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pulse_q <= pulse_d;
    end
  end

  // The reject pulse is decided when entering REJECT so new_key stays a pure register output.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pulse_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (exhausted_i) begin
          state_d = S_FAIL;
        end else if (start_i) begin
          state_d = S_FETCH;
          addr_d  = '0;
        end
      end
      S_FETCH: state_d = S_CHECK;
      S_CHECK: begin
        if (!byte_ok) begin
          state_d = S_REJECT;
          pulse_d = !exhausted_i;
        end else if (last_byte) begin
          state_d = S_FOUND;
        end else begin
          state_d = S_FETCH;
          addr_d  = addr_q + ADDR_W'(1);
        end
      end
      S_REJECT: begin
        if (pulse_q) begin
          state_d = S_IDLE;
          addr_d  = '0;
        end else begin
          state_d = S_FAIL;
        end
      end
      S_FOUND: state_d = S_FOUND;
      S_FAIL:  state_d = S_FAIL;
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_addr_o = addr_q;
  assign new_key_o = pulse_q;
  assign busy_o    = (state_q == S_FETCH) || (state_q == S_CHECK) || (state_q == S_REJECT);
  assign found_o   = (state_q == S_FOUND);
  assign failed_o  = (state_q == S_FAIL);

`ifdef KEY_CHECKER_REJECT_CNT_EN
  logic [23:0] count_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if ((state_q == S_REJECT) && pulse_q && (count_q != 24'hFFFFFF)) begin
      count_q <= count_q + 24'd1;
    end
  end

  assign reject_count_o = count_q;
`else
  assign reject_count_o = 24'h0;
`endif

endmodule

// File: tb/tb_key_checker.sv
// Self-checking bench for key_checker: RAM model, scoreboard of expected outcome/cycle per candidate.
module tb_key_checker;

  localparam int MSG_LEN   = 32;
  localparam int ADDR_W    = 5;
  localparam int K_NONE    = 0;
  localparam int K_NEWKEY  = 1;
  localparam int K_FOUND   = 2;
  localparam int K_FAIL    = 3;
`ifdef KEY_CHECKER_REJECT_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              exhausted = 1'b0;
  logic [7:0]        rd_data = 8'h00;
  logic [ADDR_W-1:0] rd_addr;
  logic              new_key, busy, found, failed;
  logic [23:0]       reject_count;
  logic [7:0]        mem [0:MSG_LEN-1];

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  key_checker #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W)) dut (
    .clk_i         (clk),
    .reset_i       (rst),
    .start_i       (start),
    .exhausted_i   (exhausted),
    .rd_data_i     (rd_data),
    .rd_addr_o     (rd_addr),
    .new_key_o     (new_key),
    .busy_o        (busy),
    .found_o       (found),
    .failed_o      (failed),
    .reject_count_o(reject_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic fill_mem(input logic [7:0] v);
    for (int i = 0; i < MSG_LEN; i++) mem[i] = v;
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    start = 1'b0;
    exhausted = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Pulses start so it is sampled at "edge 0"; cycle n is the period after edge n-1.
  task automatic start_and_wait(input int exh_cyc, output int kind, output int cyc);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    kind = K_NONE;
    cyc  = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (new_key === 1'b1) begin kind = K_NEWKEY; cyc = i; break; end
      if (found === 1'b1)   begin kind = K_FOUND;  cyc = i; break; end
      if (failed === 1'b1)  begin kind = K_FAIL;   cyc = i; break; end
      if (i == exh_cyc) exhausted = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++;
    if ({rd_addr, new_key, busy, found, failed, reject_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got addr=%0d nk=%b busy=%b found=%b failed=%b cnt=%0d, want all 0",
               rd_addr, new_key, busy, found, failed, reject_count);
    end
  endtask

  task automatic test_all_valid();
    int kind, cyc;
    exp_t e;
    do_reset();
    fill_mem(8'h61);
    sb_q.push_back('{K_FOUND, 2 * MSG_LEN + 1});
    start_and_wait(-1, kind, cyc);
    e = sb_q.pop_front();
    n_cmp++;
    if (kind !== e.kind || cyc !== e.cyc) begin
      n_bad++;
      $display("FAIL all_valid_outcome: got kind=%0d cycle=%0d, want kind=%0d cycle=%0d", kind, cyc, e.kind, e.cyc);
    end
    n_cmp++;
    if (busy !== 1'b0 || failed !== 1'b0 || rd_addr !== ADDR_W'(MSG_LEN - 1)) begin
      n_bad++;
      $display("FAIL all_valid_final: got busy=%b failed=%b addr=%0d, want 0 0 %0d", busy, failed, rd_addr, MSG_LEN - 1);
    end
    // Found is sticky and start is ignored outside IDLE.
    #1 start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (found !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL found_sticky: got found=%b busy=%b, want 1 0", found, busy);
    end
  endtask

  task automatic test_reject_byte5();
    int kind, cyc;
    exp_t e;
    do_reset();
    fill_mem(8'h61);
    mem[5] = 8'h41;
    sb_q.push_back('{K_NEWKEY, 13});
    start_and_wait(-1, kind, cyc);
    e = sb_q.pop_front();
    n_cmp++;
    if (kind !== e.kind || cyc !== e.cyc) begin
      n_bad++;
      $display("FAIL reject5_outcome: got kind=%0d cycle=%0d, want kind=%0d cycle=%0d", kind, cyc, e.kind, e.cyc);
    end
    @(negedge clk);
    n_cmp++;
    if (new_key !== 1'b0 || busy !== 1'b0 || found !== 1'b0 || rd_addr !== '0) begin
      n_bad++;
      $display("FAIL reject5_idle: got nk=%b busy=%b found=%b addr=%0d, want 0 0 0 0", new_key, busy, found, rd_addr);
    end
    n_cmp++;
    if (reject_count !== (CNT_ON ? 24'd1 : 24'd0)) begin
      n_bad++;
      $display("FAIL reject5_count: got %0d, want %0d", reject_count, CNT_ON ? 1 : 0);
    end
  endtask

  task automatic test_boundary_bytes();
    int kind, cyc;
    exp_t e;
    do_reset();
    fill_mem(8'h61);
    mem[0] = 8'h20;
    mem[MSG_LEN-1] = 8'h7A;
    sb_q.push_back('{K_FOUND, 2 * MSG_LEN + 1});
    start_and_wait(-1, kind, cyc);
    e = sb_q.pop_front();
    n_cmp++;
    if (kind !== e.kind || cyc !== e.cyc) begin
      n_bad++;
      $display("FAIL boundary_run1: got kind=%0d cycle=%0d, want kind=%0d cycle=%0d", kind, cyc, e.kind, e.cyc);
    end
    do_reset();
    mem[MSG_LEN-1] = 8'h7B;
    sb_q.push_back('{K_NEWKEY, 2 * (MSG_LEN - 1) + 3});
    start_and_wait(-1, kind, cyc);
    e = sb_q.pop_front();
    n_cmp++;
    if (kind !== e.kind || cyc !== e.cyc) begin
      n_bad++;
      $display("FAIL boundary_run2: got kind=%0d cycle=%0d, want kind=%0d cycle=%0d", kind, cyc, e.kind, e.cyc);
    end
  endtask

  task automatic test_invalid_values();
    logic [7:0] bad_vals [4];
    int kind, cyc;
    exp_t e;
    bad_vals = '{8'h00, 8'h60, 8'h1F, 8'hFF};
    do_reset();
    fill_mem(8'h61);
    for (int v = 0; v < 4; v++) begin
      fill_mem(8'h61);
      mem[v + 1] = bad_vals[v];
      sb_q.push_back('{K_NEWKEY, 2 * (v + 1) + 3});
      start_and_wait(-1, kind, cyc);
      e = sb_q.pop_front();
      n_cmp++;
      if (kind !== e.kind || cyc !== e.cyc) begin
        n_bad++;
        $display("FAIL invalid_%02h: got kind=%0d cycle=%0d, want kind=%0d cycle=%0d",
                 bad_vals[v], kind, cyc, e.kind, e.cyc);
      end
    end
  endtask

  task automatic test_exhausted_start();
    int kind, cyc;
    exp_t e;
    do_reset();
    fill_mem(8'h61);
    exhausted = 1'b1;
    sb_q.push_back('{K_FAIL, 1});
    start_and_wait(-1, kind, cyc);
    e = sb_q.pop_front();
    n_cmp++;
    if (kind !== e.kind || cyc !== e.cyc) begin
      n_bad++;
      $display("FAIL exh_start_outcome: got kind=%0d cycle=%0d, want kind=%0d cycle=%0d", kind, cyc, e.kind, e.cyc);
    end
    n_cmp++;
    if (rd_addr !== '0 || busy !== 1'b0 || found !== 1'b0 || new_key !== 1'b0) begin
      n_bad++;
      $display("FAIL exh_start_state: got addr=%0d busy=%b found=%b nk=%b, want 0 0 0 0", rd_addr, busy, found, new_key);
    end
  endtask

  task automatic test_exhaust_before_reject();
    int kind, cyc;
    exp_t e;
    do_reset();
    fill_mem(8'h61);
    mem[3] = 8'h7B;
    // Byte 3 checked in cycle 8; exhausted rises there so REJECT (cycle 9) must not pulse.
    sb_q.push_back('{K_FAIL, 10});
    start_and_wait(8, kind, cyc);
    e = sb_q.pop_front();
    n_cmp++;
    if (kind !== e.kind || cyc !== e.cyc) begin
      n_bad++;
      $display("FAIL exh_reject_outcome: got kind=%0d cycle=%0d, want kind=%0d cycle=%0d", kind, cyc, e.kind, e.cyc);
    end
    n_cmp++;
    if (found !== 1'b0 || reject_count !== 24'd0) begin
      n_bad++;
      $display("FAIL exh_reject_state: got found=%b cnt=%0d, want 0 0", found, reject_count);
    end
    exhausted = 1'b0;
  endtask

  task automatic test_reset_midscan();
    int kind, cyc;
    exp_t e;
    do_reset();
    fill_mem(8'h61);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (22) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || rd_addr !== ADDR_W'(10)) begin
      n_bad++;
      $display("FAIL midscan_pre: got busy=%b addr=%0d, want 1 10", busy, rd_addr);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({rd_addr, new_key, busy, found, failed, reject_count} !== '0) begin
      n_bad++;
      $display("FAIL midscan_async: got addr=%0d nk=%b busy=%b found=%b failed=%b, want all 0",
               rd_addr, new_key, busy, found, failed);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    sb_q.push_back('{K_FOUND, 2 * MSG_LEN + 1});
    start_and_wait(-1, kind, cyc);
    e = sb_q.pop_front();
    n_cmp++;
    if (kind !== e.kind || cyc !== e.cyc) begin
      n_bad++;
      $display("FAIL midscan_rescan: got kind=%0d cycle=%0d, want kind=%0d cycle=%0d", kind, cyc, e.kind, e.cyc);
    end
  endtask

  task automatic test_back_to_back();
    int kind, cyc;
    int errs;
    exp_t e;
    do_reset();
    fill_mem(8'h61);
    mem[0] = 8'h00;
    errs = 0;
    for (int r = 0; r < 300; r++) begin
      sb_q.push_back('{K_NEWKEY, 3});
      start_and_wait(-1, kind, cyc);
      e = sb_q.pop_front();
      n_cmp++;
      if (kind !== e.kind || cyc !== e.cyc) begin
        n_bad++;
        errs++;
        if (errs <= 5)
          $display("FAIL b2b_reject_%0d: got kind=%0d cycle=%0d, want kind=%0d cycle=%0d", r, kind, cyc, e.kind, e.cyc);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (reject_count !== (CNT_ON ? 24'd300 : 24'd0)) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d, want %0d", reject_count, CNT_ON ? 300 : 0);
    end
  endtask

  initial begin
    fill_mem(8'h61);
    test_reset();
    test_all_valid();
    test_reject_byte5();
    test_boundary_bytes();
    test_invalid_values();
    test_exhausted_start();
    test_exhaust_before_reject();
    test_reset_midscan();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
